// File: rtl/lcd_text_driver_if.sv
// -----------------------------------------------------------------------------
// lcd_text_driver_if
// Bundles the sequencer/character-write inputs and the LCD pin outputs of
// lcd_text_driver.
//   master : drives state, cnt, wr_en, wr_addr, wr_data, commit;
//            observes lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done
//   slave  : the driver itself (mirror image of master)
// -----------------------------------------------------------------------------
interface lcd_text_driver_if;
   logic [2:0] state;       // sequencer phase
   logic [8:0] cnt;         // sequencer phase counter
   logic       wr_en;       // character write strobe
   logic [4:0] wr_addr;     // character cell 0..31
   logic [7:0] wr_data;     // ASCII code
   logic       commit;      // double-buffer swap request
   logic       lcd_e;       // LCD enable strobe
   logic       lcd_rs;      // 0 = command, 1 = data
   logic       lcd_rw;      // always write
   logic [7:0] lcd_data;    // LCD data bus
   logic       frame_done;  // pulse with the last line-2 character

   modport master (
      output state, cnt, wr_en, wr_addr, wr_data, commit,
      input  lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done
   );

   modport slave (
      input  state, cnt, wr_en, wr_addr, wr_data, commit,
      output lcd_e, lcd_rs, lcd_rw, lcd_data, frame_done
   );
endinterface

// File: rtl/lcd_text_driver.sv
// -----------------------------------------------------------------------------
// lcd_text_driver
// Turns an external LCD sequencer phase (state/cnt) into registered HD44780
// style pin values, serving two 16-character lines from a 32x8 character
// buffer.
//   clk : rising-edge clock
//   rst : asynchronous, active-high reset (outputs to 0, buffer to spaces)
//   bus : lcd_text_driver_if.slave - sequencer inputs, character write port,
//         LCD pins and frame_done
// Optional build macro LCD_DBUF_EN: writes go to a back buffer that is copied
// to the displayed front buffer at the first delay_t (cnt==0) after commit.
// -----------------------------------------------------------------------------
module lcd_text_driver (
   input  logic               clk,
   input  logic               rst,
   lcd_text_driver_if.slave   bus
);

   typedef enum logic [2:0] {
      ST_DELAY   = 3'b000,
      ST_FUNC    = 3'b001,
      ST_ENTRY   = 3'b010,
      ST_DISP    = 3'b011,
      ST_LINE1   = 3'b100,
      ST_LINE2   = 3'b101,
      ST_DELAY_T = 3'b110,
      ST_CLEAR   = 3'b111
   } phase_t;

   phase_t phase;
   assign phase = phase_t'(bus.state);

   // Displayed character cells
   logic [7:0] front_reg [32];

`ifdef LCD_DBUF_EN
   logic [7:0] back_reg [32];
   logic       pending_reg;
   logic       swap;

   assign swap = (phase == ST_DELAY_T) && (bus.cnt == 9'd0) && pending_reg;

   // A commit arriving on the swap edge itself survives for the next delay_t.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pending_reg <= 1'b0;
      else if (swap)
         pending_reg <= bus.commit;
      else
         pending_reg <= pending_reg | bus.commit;
   end

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_cell
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               back_reg[gi] <= 8'h20;
            else if (bus.wr_en && bus.wr_addr == 5'(gi))
               back_reg[gi] <= bus.wr_data;
         end

         // Front takes the back value from before this edge's write.
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               front_reg[gi] <= 8'h20;
            else if (swap)
               front_reg[gi] <= back_reg[gi];
         end
      end
   endgenerate
`else
   logic unused_commit;
   assign unused_commit = bus.commit;

   generate
      for (genvar gi = 0; gi < 32; gi++) begin : g_cell
         always_ff @(posedge clk or posedge rst) begin
            if (rst)
               front_reg[gi] <= 8'h20;
            else if (bus.wr_en && bus.wr_addr == 5'(gi))
               front_reg[gi] <= bus.wr_data;
         end
      end
   endgenerate
`endif

   // Cell addressed by the current line phase: line select in bit 4,
   // cnt-1 in the low nibble (only used for cnt 1..16).
   logic [3:0] rd_low;
   logic [4:0] rd_addr;
   assign rd_low  = bus.cnt[3:0] - 4'd1;
   assign rd_addr = {phase == ST_LINE2, rd_low};

   logic       e_next, rs_next, fd_next;
   logic [7:0] data_next;
   logic [7:0] cmd_byte;

   always_comb begin
      cmd_byte = 8'h00;
      case (phase)
         ST_FUNC:  cmd_byte = 8'h38;
         ST_ENTRY: cmd_byte = 8'h06;
         ST_DISP:  cmd_byte = 8'h0C;
         ST_CLEAR: cmd_byte = 8'h01;
         default:  cmd_byte = 8'h00;
      endcase
   end

   always_comb begin
      e_next    = 1'b0;
      rs_next   = 1'b0;
      data_next = 8'h00;
      fd_next   = 1'b0;
      case (phase)
         ST_FUNC, ST_ENTRY, ST_DISP, ST_CLEAR: begin
            if (bus.cnt <= 9'd400) begin
               data_next = cmd_byte;
               e_next    = (bus.cnt == 9'd1);
            end
         end
         ST_LINE1, ST_LINE2: begin
            if (bus.cnt == 9'd0) begin
               e_next    = 1'b1;
               data_next = (phase == ST_LINE2) ? 8'hC0 : 8'h80;
            end else if (bus.cnt <= 9'd16) begin
               e_next    = 1'b1;
               rs_next   = 1'b1;
               // Read before this edge's write lands: same-cell write shows old data.
               data_next = front_reg[rd_addr];
            end
            fd_next = (phase == ST_LINE2) && (bus.cnt == 9'd16);
         end
         default: ;
      endcase
   end

   logic       e_reg, rs_reg, fd_reg;
   logic [7:0] data_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e_reg    <= 1'b0;
         rs_reg   <= 1'b0;
         data_reg <= 8'h00;
         fd_reg   <= 1'b0;
      end else begin
         e_reg    <= e_next;
         rs_reg   <= rs_next;
         data_reg <= data_next;
         fd_reg   <= fd_next;
      end
   end

   assign bus.lcd_e      = e_reg;
   assign bus.lcd_rs     = rs_reg;
   assign bus.lcd_rw     = 1'b0;
   assign bus.lcd_data   = data_reg;
   assign bus.frame_done = fd_reg;

endmodule

// File: tb/tb_lcd_text_driver.sv
// -----------------------------------------------------------------------------
// tb_lcd_text_driver
// Self-checking bench for lcd_text_driver: a table of command/idle vectors plus
// buffer sequences checked against a reference character-buffer model through
// a scoreboard queue (one expectation per driven cycle, compared one edge later).
// -----------------------------------------------------------------------------
module tb_lcd_text_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lcd_text_driver_if bus ();

   lcd_text_driver dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [2:0] st;
      logic [8:0] cnt;
      logic       e;
      logic       rs;
      logic [7:0] d;
      logic       fd;
   } vec_t;

   vec_t sbq[$];
   vec_t vtab[15];

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] mfront [32];
   logic [7:0] mback  [32];
   logic       mpend;

   function automatic vec_t model(input logic [2:0] st, input logic [8:0] c);
      vec_t r;
      int   idx;
      r.st = st; r.cnt = c; r.e = 1'b0; r.rs = 1'b0; r.d = 8'h00; r.fd = 1'b0;
      case (st)
         3'b001: if (c <= 400) begin r.d = 8'h38; r.e = (c == 1); end
         3'b010: if (c <= 400) begin r.d = 8'h06; r.e = (c == 1); end
         3'b011: if (c <= 400) begin r.d = 8'h0C; r.e = (c == 1); end
         3'b111: if (c <= 400) begin r.d = 8'h01; r.e = (c == 1); end
         3'b100, 3'b101: begin
            if (c == 0) begin
               r.e = 1'b1;
               r.d = (st == 3'b100) ? 8'h80 : 8'hC0;
            end else if (c <= 16) begin
               idx  = ((st == 3'b101) ? 16 : 0) + int'(c) - 1;
               r.e  = 1'b1;
               r.rs = 1'b1;
               r.d  = mfront[idx];
            end
            r.fd = (st == 3'b101) && (c == 16);
         end
         default: ;
      endcase
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 32; i++) begin
         mfront[i] = 8'h20;
         mback[i]  = 8'h20;
      end
      mpend = 1'b0;
   endtask

   task automatic model_edge(input logic [2:0] st, input logic [8:0] c, input logic we,
                             input logic [4:0] wa, input logic [7:0] wd, input logic cm);
`ifdef LCD_DBUF_EN
      if (st == 3'b110 && c == 0 && mpend) begin
         for (int i = 0; i < 32; i++) mfront[i] = mback[i];
         mpend = cm;
      end else begin
         mpend = mpend | cm;
      end
      if (we) mback[wa] = wd;
`else
      if (st == 3'b000 && c == 0 && cm) mpend = 1'b0;  // commit has no effect
      if (we) mfront[wa] = wd;
`endif
   endtask

   task automatic check_out();
      vec_t x;
      if (sbq.size() != 0) begin
         x = sbq.pop_front();
         n_checks++;
         if ({bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data, bus.frame_done} ===
             {x.e, x.rs, 1'b0, x.d, x.fd}) begin
            n_pass++;
            $display("ok   out st=%0d cnt=%0d e=%b rs=%b data=%h fd=%b",
                     x.st, x.cnt, bus.lcd_e, bus.lcd_rs, bus.lcd_data, bus.frame_done);
         end else begin
            $display("FAIL out st=%0d cnt=%0d got e=%b rs=%b rw=%b data=%h fd=%b want e=%b rs=%b rw=0 data=%h fd=%b",
                     x.st, x.cnt, bus.lcd_e, bus.lcd_rs, bus.lcd_rw, bus.lcd_data,
                     bus.frame_done, x.e, x.rs, x.d, x.fd);
         end
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) begin
         n_pass++;
         $display("ok   %s = %0h", name, act);
      end else begin
         $display("FAIL %s got %0h want %0h", name, act, exp);
      end
   endtask

   // One cycle: compare the previous cycle's expectation, then drive new inputs.
   task automatic apply(input logic [2:0] st, input logic [8:0] c, input logic we,
                        input logic [4:0] wa, input logic [7:0] wd, input logic cm,
                        input vec_t ex);
      @(negedge clk);
      check_out();
      bus.state   = st;
      bus.cnt     = c;
      bus.wr_en   = we;
      bus.wr_addr = wa;
      bus.wr_data = wd;
      bus.commit  = cm;
      sbq.push_back(ex);
      model_edge(st, c, we, wa, wd, cm);
   endtask

   task automatic tick(input logic [2:0] st, input logic [8:0] c, input logic we,
                       input logic [4:0] wa, input logic [7:0] wd, input logic cm);
      apply(st, c, we, wa, wd, cm, model(st, c));
   endtask

   task automatic run_line(input logic [2:0] st, input int last);
      for (int c = 0; c <= last; c++) tick(st, 9'(c), 1'b0, 5'd0, 8'h00, 1'b0);
   endtask

   initial begin
      bus.state = 3'b100; bus.cnt = 9'd0; bus.wr_en = 1'b0;
      bus.wr_addr = 5'd0; bus.wr_data = 8'h00; bus.commit = 1'b0;
      model_reset();

      // Reset values held across edges even with an active line phase
      repeat (3) @(negedge clk);
      chk("rst_e",    {31'd0, bus.lcd_e},      32'd0);
      chk("rst_rs",   {31'd0, bus.lcd_rs},     32'd0);
      chk("rst_rw",   {31'd0, bus.lcd_rw},     32'd0);
      chk("rst_data", {24'd0, bus.lcd_data},   32'd0);
      chk("rst_fd",   {31'd0, bus.frame_done}, 32'd0);
      rst = 1'b0;

      // Command / idle vector table
      vtab[0]  = '{3'b001, 9'd0,   1'b0, 1'b0, 8'h38, 1'b0};
      vtab[1]  = '{3'b001, 9'd1,   1'b1, 1'b0, 8'h38, 1'b0};
      vtab[2]  = '{3'b001, 9'd2,   1'b0, 1'b0, 8'h38, 1'b0};
      vtab[3]  = '{3'b010, 9'd1,   1'b1, 1'b0, 8'h06, 1'b0};
      vtab[4]  = '{3'b010, 9'd5,   1'b0, 1'b0, 8'h06, 1'b0};
      vtab[5]  = '{3'b011, 9'd1,   1'b1, 1'b0, 8'h0C, 1'b0};
      vtab[6]  = '{3'b111, 9'd1,   1'b1, 1'b0, 8'h01, 1'b0};
      vtab[7]  = '{3'b111, 9'd400, 1'b0, 1'b0, 8'h01, 1'b0};
      vtab[8]  = '{3'b111, 9'd401, 1'b0, 1'b0, 8'h00, 1'b0};
      vtab[9]  = '{3'b000, 9'd1,   1'b0, 1'b0, 8'h00, 1'b0};
      vtab[10] = '{3'b110, 9'd1,   1'b0, 1'b0, 8'h00, 1'b0};
      vtab[11] = '{3'b100, 9'd0,   1'b1, 1'b0, 8'h80, 1'b0};
      vtab[12] = '{3'b101, 9'd0,   1'b1, 1'b0, 8'hC0, 1'b0};
      vtab[13] = '{3'b100, 9'd17,  1'b0, 1'b0, 8'h00, 1'b0};
      vtab[14] = '{3'b101, 9'd300, 1'b0, 1'b0, 8'h00, 1'b0};
      for (int i = 0; i < 15; i++)
         apply(vtab[i].st, vtab[i].cnt, 1'b0, 5'd0, 8'h00, 1'b0, vtab[i]);

      // function_set sweep: single enable pulse, 0x38 throughout
      for (int c = 0; c <= 30; c++)
         apply(3'b001, 9'(c), 1'b0, 5'd0, 8'h00, 1'b0,
               '{3'b001, 9'(c), (c == 1), 1'b0, 8'h38, 1'b0});

      // "HELLO" into cells 0..4, then line 1 frame
      tick(3'b000, 9'd5, 1'b1, 5'd0, 8'h48, 1'b0);
      tick(3'b000, 9'd5, 1'b1, 5'd1, 8'h45, 1'b0);
      tick(3'b000, 9'd5, 1'b1, 5'd2, 8'h4C, 1'b0);
      tick(3'b000, 9'd5, 1'b1, 5'd3, 8'h4C, 1'b0);
      tick(3'b000, 9'd5, 1'b1, 5'd4, 8'h4F, 1'b0);
      run_line(3'b100, 20);

      // Stalled sequencer: same cell re-read
      repeat (3) tick(3'b100, 9'd3, 1'b0, 5'd0, 8'h00, 1'b0);

      // Same-cycle write/read of cell 16, then next frame shows the new value
      tick(3'b101, 9'd0, 1'b0, 5'd0, 8'h00, 1'b0);
      tick(3'b101, 9'd1, 1'b1, 5'd16, 8'h41, 1'b0);
      for (int c = 2; c <= 20; c++) tick(3'b101, 9'(c), 1'b0, 5'd0, 8'h00, 1'b0);
      tick(3'b101, 9'd1, 1'b1, 5'd31, 8'h5A, 1'b0);
      run_line(3'b101, 20);

`ifdef LCD_DBUF_EN
      // Back-buffer write stays hidden until the delay_t swap
      tick(3'b000, 9'd0, 1'b1, 5'd0, 8'h58, 1'b1);
      run_line(3'b100, 2);
      tick(3'b110, 9'd0, 1'b0, 5'd0, 8'h00, 1'b0);
      run_line(3'b100, 2);
      // Commit on the swap edge is kept for the following delay_t
      tick(3'b000, 9'd0, 1'b1, 5'd1, 8'h59, 1'b1);
      tick(3'b110, 9'd0, 1'b1, 5'd2, 8'h51, 1'b1);
      run_line(3'b100, 4);
      tick(3'b110, 9'd0, 1'b0, 5'd0, 8'h00, 1'b0);
      run_line(3'b100, 4);
`endif

      // Asynchronous reset in the middle of line 1
      run_line(3'b100, 8);
      @(negedge clk);
      check_out();
      #1 rst = 1'b1;
      #1;
      chk("arst_e",    {31'd0, bus.lcd_e},      32'd0);
      chk("arst_rs",   {31'd0, bus.lcd_rs},     32'd0);
      chk("arst_data", {24'd0, bus.lcd_data},   32'd0);
      chk("arst_fd",   {31'd0, bus.frame_done}, 32'd0);
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      run_line(3'b100, 17);
      run_line(3'b101, 17);
      tick(3'b000, 9'd0, 1'b0, 5'd0, 8'h00, 1'b0);
      @(negedge clk);
      check_out();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
